// File: rtl/boot_load_ctrl_if.sv
// Program-load stream into the boot controller plus the registered instruction-memory write port it drives.
interface boot_load_ctrl_if #(
  parameter int AW = 10
);
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_last;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/boot_load_ctrl.sv
// Boot controller: streams a program into instruction memory with the core held in reset,
// releases the core, then ends the run on a HALT_ADDR pc match or a cycle-limit timeout.
module boot_load_ctrl #(
  parameter int          AW         = 10,
  parameter logic [31:0] HALT_ADDR  = 32'h100,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  boot_load_ctrl_if.slave      bus,
  input  logic                 restart,
  output logic                 cpu_reset,
  input  logic [31:0]          pc,
  output logic                 done,
  output logic                 timeout,
  output logic                 overflow,
  output logic [31:0]          cycle_count
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_DONE, S_TIMEOUT
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [31:0]   MAX_C     = 32'(MAX_CYCLES);

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          imem_we_q, imem_we_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]   imem_wdata_q, imem_wdata_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   cycle_count_q, cycle_count_d;

  logic          ready;
  logic          accept;
  logic          halt_hit;
  logic [31:0]   count_inc;

  assign accept    = bus.in_valid & ready;
  assign halt_hit  = (pc == HALT_ADDR);
  assign count_inc = cycle_count_q + 32'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (accept) state_d = bus.in_last ? S_RELEASE : S_LOAD;
      // Filling the last word without in_last is an overflow: stop loading and run what we have.
      S_LOAD:    if (accept && (bus.in_last || wptr_q == LAST_ADDR)) state_d = S_RELEASE;
      S_RELEASE: state_d = S_RUN;
      S_RUN: begin
        if (halt_hit)                state_d = S_DONE;
        else if (count_inc == MAX_C) state_d = S_TIMEOUT;
      end
      S_DONE, S_TIMEOUT: if (restart) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == S_IDLE) || (state_q == S_LOAD);
    cpu_reset = (state_q == S_RUN);
  end

  always_comb begin
    wptr_d        = wptr_q;
    imem_we_d     = accept;
    imem_addr_d   = imem_addr_q;
    imem_wdata_d  = imem_wdata_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    overflow_d    = overflow_q;
    cycle_count_d = cycle_count_q;
    if (accept) begin
      imem_addr_d  = wptr_q;
      imem_wdata_d = bus.in_data;
      wptr_d       = wptr_q + 1'b1;
      if (state_q == S_LOAD && !bus.in_last && wptr_q == LAST_ADDR) overflow_d = 1'b1;
    end
    unique case (state_q)
      S_RELEASE: cycle_count_d = '0;
      S_RUN: begin
        cycle_count_d = count_inc;
        if (halt_hit)                done_d    = 1'b1;
        else if (count_inc == MAX_C) timeout_d = 1'b1;
      end
      S_DONE, S_TIMEOUT: begin
        if (restart) begin
          done_d        = 1'b0;
          timeout_d     = 1'b0;
          overflow_d    = 1'b0;
          cycle_count_d = '0;
          wptr_d        = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q        <= '0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      wptr_q        <= wptr_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      overflow_q    <= overflow_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign overflow       = overflow_q;
  assign cycle_count    = cycle_count_q;
endmodule
